plusarg_sim_watchdog: RTL
=========================

Name: plusarg_sim_watchdog

Overview:
- Simulation-harness controller that sequences end-of-test for a run, using limits supplied by plusarg_reader instances (e.g. +max_cycles, +stall_limit).
- Counts run cycles and heartbeat-free cycles, and arbitrates pass/fail/timeout/stall events by a fixed priority into one sticky terminal verdict.
- Sits in the TestHarness next to the DUT. Its done/verdict outputs drive the harness success/failure reporting.

Parameters:
- CYCLE_W, 64, width of cfg_max_cycles and cycle_count.
- STALL_W, 32, width of cfg_stall_limit and the internal stall counter.

Ports:
- clock  input  1  sole clock
- reset  input  1  synchronous, active-high reset
- cfg_max_cycles  input  CYCLE_W  run-cycle limit; 0 disables timeout
- cfg_stall_limit  input  STALL_W  maximum consecutive heartbeat-free run cycles; 0 disables stall check
- start  input  1  begin run; sampled only in IDLE
- heartbeat  input  1  DUT progress pulse, e.g. instruction retired
- success  input  1  DUT reports pass
- fail_in  input  1  DUT or monitor reports failure
- active  output  1  state == RUN
- passed  output  1  terminal PASS
- failed  output  1  terminal FAIL_EXT
- timed_out  output  1  terminal FAIL_TIMEOUT
- stalled  output  1  terminal FAIL_STALL
- done  output  1  OR of the four terminal flags
- cycle_count  output  CYCLE_W  run cycles elapsed

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered and decoded directly from state and counters.
- Reset values: state IDLE, all flags 0, cycle_count 0, stall counter 0.
- Reset asserted mid-run takes effect at the next edge: returns to IDLE and clears the counters.
- States: IDLE, RUN, PASS, FAIL_EXT, FAIL_TIMEOUT, FAIL_STALL. The four terminal states hold until reset.
- IDLE:
  - When start is high: latch cfg_max_cycles and cfg_stall_limit into internal registers, clear both counters, go to RUN.
  - All other inputs are ignored.
  - Later changes to cfg_* have no effect until the next start in IDLE.
- RUN, evaluated on each edge in this priority order:
  1. fail_in -> FAIL_EXT.
  2. else success -> PASS.
  3. else if latched max != 0 and cycle_count + 1 == max -> FAIL_TIMEOUT.
  4. else if latched limit != 0, heartbeat low, and stall_cnt + 1 == limit -> FAIL_STALL.
  5. else stay in RUN.
- Counters in RUN:
  - cycle_count increments by 1 on every RUN edge, including the edge that exits RUN.
  - cycle_count saturates at all-ones and never wraps.
  - stall_cnt is cleared to 0 when heartbeat is high, otherwise increments, saturating at all-ones.
  - Both counters freeze in terminal states, so cycle_count reports the final run length.
- start while in RUN or a terminal state is ignored.
- Latency:
  - A fail_in/success sampled at edge N shows its flag and done after edge N.
  - With max = M, timed_out rises after the M-th RUN edge; cycle_count then reads M.
  - With limit = L and no heartbeat, stalled rises after L consecutive heartbeat-free RUN edges.
- Simultaneous events: fail_in beats success beats timeout beats stall. A heartbeat on the limit cycle prevents the stall.
- Limit of 1: the first RUN edge triggers timeout or stall, subject to the priority above.

Test Plan:
- Timeout: reset, max=10, limit=0, pulse start, no other events -> timed_out=1 and done=1 after 10 RUN edges; cycle_count=10; passed/failed/stalled stay 0.
- Pass before limit: max=100, success pulsed on RUN edge 5 -> passed=1, cycle_count=5, flags held for 50 further cycles.
- Simultaneous events: max=3, fail_in and success both high on RUN edge 3 -> failed=1, passed=0, timed_out=0.
- Stall check, part 1: limit=4, max=0, heartbeat high on RUN edges 1-3, then low -> stalled=1 after edge 7.
- Stall check, part 2: repeat with heartbeat high on edge 7 -> no stall on edge 7; stall fires at edge 11.
- Reset mid-run: reset asserted at RUN edge 20 -> next cycle state IDLE, cycle_count=0; a second start with max=2 -> timed_out at RUN edge 2.
- Disabled limits and saturation: max=0, limit=0, CYCLE_W=4 build, run 20 edges -> no terminal flag, cycle_count saturates at 15; cfg changes during RUN are ignored.

Source files
------------

// File: rtl/plusarg_sim_watchdog.sv
// End-of-test sequencer for a simulation harness: counts run cycles and
// heartbeat-free cycles and resolves pass/fail/timeout/stall into one sticky verdict.
module plusarg_sim_watchdog #(
    parameter int unsigned CYCLE_W = 64,
    parameter int unsigned STALL_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CYCLE_W-1:0] cfg_max_cycles,
    input  logic [STALL_W-1:0] cfg_stall_limit,
    input  logic               start,
    input  logic               heartbeat,
    input  logic               success,
    input  logic               fail_in,
    output logic               active,
    output logic               passed,
    output logic               failed,
    output logic               timed_out,
    output logic               stalled,
    output logic               done,
    output logic [CYCLE_W-1:0] cycle_count
);

    localparam int unsigned CYC_SUM_W   = CYCLE_W + 1;
    localparam int unsigned STALL_SUM_W = STALL_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL_EXT,
        ST_FAIL_TIMEOUT,
        ST_FAIL_STALL
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CYCLE_W-1:0]   r_max;
    logic [CYCLE_W-1:0]   w_max_nxt;
    logic [STALL_W-1:0]   r_limit;
    logic [STALL_W-1:0]   w_limit_nxt;
    logic [CYCLE_W-1:0]   r_cycle_count;
    logic [CYCLE_W-1:0]   w_cycle_nxt;
    logic [STALL_W-1:0]   r_stall_cnt;
    logic [STALL_W-1:0]   w_stall_nxt;

    logic                 r_active;
    logic                 r_passed;
    logic                 r_failed;
    logic                 r_timed_out;
    logic                 r_stalled;
    logic                 r_done;

    // Increments computed one bit wider so a saturated counter can never match a limit
    logic [CYC_SUM_W-1:0]   w_cyc_sum;
    logic [STALL_SUM_W-1:0] w_stall_sum;
    logic                   w_cyc_sat;
    logic                   w_stall_sat;
    logic                   w_timeout_hit;
    logic                   w_stall_hit;

    assign w_cyc_sum     = {1'b0, r_cycle_count} + CYC_SUM_W'(1);
    assign w_stall_sum   = {1'b0, r_stall_cnt} + STALL_SUM_W'(1);
    assign w_cyc_sat     = &r_cycle_count;
    assign w_stall_sat   = &r_stall_cnt;
    assign w_timeout_hit = (r_max != '0) && (w_cyc_sum == {1'b0, r_max});
    assign w_stall_hit   = (r_limit != '0) && !heartbeat
                           && (w_stall_sum == {1'b0, r_limit});

    // Next-state, limit latching and counter update
    always_comb begin
        w_state_nxt = r_state;
        w_max_nxt   = r_max;
        w_limit_nxt = r_limit;
        w_cycle_nxt = r_cycle_count;
        w_stall_nxt = r_stall_cnt;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_max_nxt   = cfg_max_cycles;
                    w_limit_nxt = cfg_stall_limit;
                    w_cycle_nxt = '0;
                    w_stall_nxt = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_cycle_nxt = w_cyc_sat ? r_cycle_count : w_cyc_sum[CYCLE_W-1:0];
                if (heartbeat) begin
                    w_stall_nxt = '0;
                end else begin
                    w_stall_nxt = w_stall_sat ? r_stall_cnt : w_stall_sum[STALL_W-1:0];
                end

                if (fail_in) begin
                    w_state_nxt = ST_FAIL_EXT;
                end else if (success) begin
                    w_state_nxt = ST_PASS;
                end else if (w_timeout_hit) begin
                    w_state_nxt = ST_FAIL_TIMEOUT;
                end else if (w_stall_hit) begin
                    w_state_nxt = ST_FAIL_STALL;
                end
            end
            default: begin
                // Terminal states hold with counters frozen until reset
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_max         <= '0;
            r_limit       <= '0;
            r_cycle_count <= '0;
            r_stall_cnt   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_max         <= w_max_nxt;
            r_limit       <= w_limit_nxt;
            r_cycle_count <= w_cycle_nxt;
            r_stall_cnt   <= w_stall_nxt;
        end
    end

    // Status flags registered from the next state so they track r_state exactly
    always_ff @(posedge clock) begin
        if (reset) begin
            r_active    <= 1'b0;
            r_passed    <= 1'b0;
            r_failed    <= 1'b0;
            r_timed_out <= 1'b0;
            r_stalled   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_active    <= (w_state_nxt == ST_RUN);
            r_passed    <= (w_state_nxt == ST_PASS);
            r_failed    <= (w_state_nxt == ST_FAIL_EXT);
            r_timed_out <= (w_state_nxt == ST_FAIL_TIMEOUT);
            r_stalled   <= (w_state_nxt == ST_FAIL_STALL);
            r_done      <= (w_state_nxt == ST_PASS)
                        || (w_state_nxt == ST_FAIL_EXT)
                        || (w_state_nxt == ST_FAIL_TIMEOUT)
                        || (w_state_nxt == ST_FAIL_STALL);
        end
    end

    assign active      = r_active;
    assign passed      = r_passed;
    assign failed      = r_failed;
    assign timed_out   = r_timed_out;
    assign stalled     = r_stalled;
    assign done        = r_done;
    assign cycle_count = r_cycle_count;

endmodule
